probe_uart_tx: RTL and testbench

//  Debug sink downstream of the processor top level: consumes the 32-bit probe word it exports.

---
 rtl/probe_uart_tx.sv | 190 +++++++++++++++++++
 tb/tb_probe_uart_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/probe_uart_tx.sv
// probe_uart_tx: debug sink for the processor's 32-bit probe word.
// Each new probe value is sent on a UART TX line as 8 uppercase ASCII hex digits
// (most significant nibble first), followed by CR LF. A one-entry pending slot
// sits between the probe and the slow serial link. If a pending value is replaced
// before it has been sent, overrun pulses for one cycle.
//
// Build option: define PROBE_UART_PARITY_EN to add an even-parity bit after the
// data bits (11-bit frame). Without it each character is sent as plain 8N1.
//
// Ports:
//   clock     in   1   master clock, rising edge
//   reset     in   1   asynchronous reset, active low
//   probe     in   32  probe word, sampled on every clock
//   send_req  in   1   one-cycle pulse: queue the current probe even if it has not changed
//   tx        out  1   UART serial output, idle high, LSB first
//   busy      out  1   high while a message is being shifted out
//   overrun   out  1   one-cycle pulse: a pending, unsent value was overwritten
module probe_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] probe,
    input  logic        send_req,
    output logic        tx,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef PROBE_UART_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [3:0]      char_idx_q;
    logic [31:0]     msg_q;
    logic [31:0]     pending_q;
    logic            pending_valid_q;
    logic [31:0]     last_seen_q;
    logic            overrun_q;

    logic            tick;
    logic            last_char;
    logic            evt;
    logic            take;
    logic [3:0]      nibble;
    logic [7:0]      cur_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        // 'A' - 10 = 0x37
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign tick      = (cnt_q == CntLast);
    assign last_char = (char_idx_q == 4'd9);
    assign evt       = (probe != last_seen_q) | send_req;
    // Pending entry is consumed when a message starts, either from idle or
    // directly after the final STOP of the previous message.
    assign take      = pending_valid_q &&
                       ((state_q == StIdle) || ((state_q == StStop) && tick && last_char));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pending_valid_q) state_d = StStart;
            end
            StStart: begin
                if (tick) state_d = StData;
            end
            StData: begin
                if (tick && (bit_idx_q == 3'd7)) begin
`ifdef PROBE_UART_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef PROBE_UART_PARITY_EN
            StParity: begin
                if (tick) state_d = StStop;
            end
`endif
            StStop: begin
                if (tick) begin
                    if (!last_char || pending_valid_q) state_d = StStart;
                    else                               state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Character currently on the wire
    always_comb begin
        nibble = 4'h0;
        case (char_idx_q)
            4'd0:    nibble = msg_q[31:28];
            4'd1:    nibble = msg_q[27:24];
            4'd2:    nibble = msg_q[23:20];
            4'd3:    nibble = msg_q[19:16];
            4'd4:    nibble = msg_q[15:12];
            4'd5:    nibble = msg_q[11:8];
            4'd6:    nibble = msg_q[7:4];
            4'd7:    nibble = msg_q[3:0];
            default: nibble = 4'h0;
        endcase
        if (char_idx_q == 4'd8)      cur_char = 8'h0D;
        else if (char_idx_q == 4'd9) cur_char = 8'h0A;
        else                         cur_char = hex_ascii(nibble);
    end

    // Outputs, decoded from the registered state so reset forces them at once
    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            StIdle:   tx = 1'b1;
            StStart:  tx = 1'b0;
            StData:   tx = cur_char[bit_idx_q];
`ifdef PROBE_UART_PARITY_EN
            StParity: tx = ^cur_char;
`endif
            StStop:   tx = 1'b1;
            default:  tx = 1'b1;
        endcase
        busy    = (state_q != StIdle);
        overrun = overrun_q;
    end

    // Bit timing, character sequencing and the pending slot
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q           <= '0;
            bit_idx_q       <= 3'd0;
            char_idx_q      <= 4'd0;
            msg_q           <= 32'h0;
            pending_q       <= 32'h0;
            pending_valid_q <= 1'b0;
            last_seen_q     <= 32'h0;
            overrun_q       <= 1'b0;
        end else begin
            if ((state_q == StIdle) || tick) cnt_q <= '0;
            else                             cnt_q <= cnt_q + 1'b1;

            // Wraps 7 -> 0 on its own, so every character starts at bit 0
            if ((state_q == StData) && tick) bit_idx_q <= bit_idx_q + 3'd1;

            if (take) begin
                char_idx_q <= 4'd0;
            end else if ((state_q == StStop) && tick) begin
                char_idx_q <= last_char ? 4'd0 : (char_idx_q + 4'd1);
            end

            if (take) msg_q <= pending_q;

            if (evt) begin
                pending_q   <= probe;
                last_seen_q <= probe;
            end

            if (evt)       pending_valid_q <= 1'b1;
            else if (take) pending_valid_q <= 1'b0;

            overrun_q <= evt && pending_valid_q && !take;
        end
    end

endmodule

// File: tb/tb_probe_uart_tx.sv
module tb_probe_uart_tx;

    localparam int CPB = 4;
`ifdef PROBE_UART_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int MSG_CYCLES = 10 * FRAME * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] probe = 32'h0;
    logic        send_req = 1'b0;
    logic        tx;
    logic        busy;
    logic        overrun;

    probe_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .probe   (probe),
        .send_req(send_req),
        .tx      (tx),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int busy_cnt = 0;
    int ovr_cnt = 0;
    int busy_fall = 0;
    int rx_cnt = 0;
    int tx_low_cnt = 0;
    bit mon_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bytes come from $sformatf, converted to uppercase
    task automatic push_msg(input logic [31:0] v);
        string s;
        logic [7:0] c;
        s = $sformatf("%h", v);
        for (int i = 0; i < 8; i++) begin
            c = s[i];
            if (c >= "a" && c <= "f") c = c - 8'd32;
            exp_q.push_back(c);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((busy || (exp_q.size() != 0) || mon_active) && (n < 3000)) begin
            @(negedge clock);
            n++;
        end
        check(name, (n >= 3000) ? 32'd1 : 32'd0, 32'd0);
        repeat (3) @(negedge clock);
    endtask

    // UART receiver and activity counters, sampled on the falling edge
    initial begin : monitor
        int cnt;
        logic [7:0] b;
        logic prev_busy;
        cnt = 0;
        b = 8'h0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (busy) busy_cnt++;
            if (overrun) ovr_cnt++;
            if (!tx) tx_low_cnt++;
            if (prev_busy && !busy) busy_fall++;
            prev_busy = busy;
            if (!reset) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (!tx) begin
                    mon_active = 1'b1;
                    cnt = 0;
                    b = 8'h0;
                end
            end else begin
                cnt++;
                for (int i = 0; i < 8; i++) begin
                    if (cnt == CPB * (i + 1) + CPB / 2) b[i] = tx;
                end
`ifdef PROBE_UART_PARITY_EN
                if (cnt == CPB * 9 + CPB / 2) check("parity_bit", {31'b0, tx}, {31'b0, ^b});
`endif
                if (cnt == CPB * (FRAME - 1) + CPB / 2) begin
                    check("stop_bit", {31'b0, tx}, 32'd1);
                    rx_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rx_unexpected: got byte %0h, expected none", b);
                    end else begin
                        check("rx_byte", {24'h0, b}, {24'h0, exp_q.pop_front()});
                    end
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] probe;
        logic        send_req;
        logic        has_msg;
    } vec_t;

    initial begin : main
        vec_t vecs[7];
        int b0, o0, f0, r0;

        vecs[0] = '{probe: 32'h1234ABCD, send_req: 1'b0, has_msg: 1'b1};
        vecs[1] = '{probe: 32'h1234ABCD, send_req: 1'b1, has_msg: 1'b1};  // resend unchanged
        vecs[2] = '{probe: 32'h00000009, send_req: 1'b1, has_msg: 1'b1};  // change + req = one
        vecs[3] = '{probe: 32'h00000009, send_req: 1'b0, has_msg: 1'b0};  // unchanged: silent
        vecs[4] = '{probe: 32'hFFFFFFFF, send_req: 1'b0, has_msg: 1'b1};
        vecs[5] = '{probe: 32'h00000001, send_req: 1'b0, has_msg: 1'b1};
        vecs[6] = '{probe: 32'h0F1E2D3C, send_req: 1'b0, has_msg: 1'b1};

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_overrun", {31'b0, overrun}, 32'd0);
        reset = 1'b1;

        // Probe held at zero: no traffic
        repeat (500) @(negedge clock);
        check("idle_busy_cycles", busy_cnt, 0);
        check("idle_overruns", ovr_cnt, 0);
        check("idle_tx_low", tx_low_cnt, 0);
        check("idle_rx_bytes", rx_cnt, 0);

        for (int v = 0; v < 7; v++) begin
            b0 = busy_cnt;
            o0 = ovr_cnt;
            probe = vecs[v].probe;
            send_req = vecs[v].send_req;
            if (vecs[v].has_msg) push_msg(vecs[v].probe);
            @(negedge clock);
            send_req = 1'b0;
            repeat (30) @(negedge clock);
            wait_done($sformatf("vec%0d_timeout", v));
            check($sformatf("vec%0d_busy_cycles", v), busy_cnt - b0,
                  vecs[v].has_msg ? MSG_CYCLES : 0);
            check($sformatf("vec%0d_overruns", v), ovr_cnt - o0, 0);
        end

        // Overrun during a message, then back-to-back follow-up
        b0 = busy_cnt;
        o0 = ovr_cnt;
        f0 = busy_fall;
        probe = 32'hDEADBEEF;
        push_msg(32'hDEADBEEF);
        repeat (20) @(negedge clock);
        probe = 32'h5;
        repeat (10) @(negedge clock);
        probe = 32'h6;
        push_msg(32'h6);
        wait_done("ovr_timeout");
        check("ovr_pulses", ovr_cnt - o0, 1);
        check("ovr_busy_cycles", busy_cnt - b0, 2 * MSG_CYCLES);
        check("ovr_back_to_back", busy_fall - f0, 1);

        // Reset in mid-message aborts it
        r0 = rx_cnt;
        probe = 32'h11111111;
        begin
            int n;
            n = 0;
            while (!busy && n < 50) begin
                @(negedge clock);
                n++;
            end
            check("abort_start_timeout", (n >= 50) ? 32'd1 : 32'd0, 32'd0);
        end
        repeat (37) @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_tx", {31'b0, tx}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_overrun", {31'b0, overrun}, 32'd0);
        repeat (4) @(negedge clock);
        check("abort_rx_bytes", rx_cnt - r0, 0);
        probe = 32'h7;
        @(negedge clock);
        reset = 1'b1;
        b0 = busy_cnt;
        push_msg(32'h7);
        @(negedge clock);
        check("lat_e0_tx", {31'b0, tx}, 32'd1);
        check("lat_e0_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        check("lat_e1_tx", {31'b0, tx}, 32'd0);
        check("lat_e1_busy", {31'b0, busy}, 32'd1);
        wait_done("post_reset_timeout");
        check("post_reset_busy_cycles", busy_cnt - b0, MSG_CYCLES);

        repeat (20) @(negedge clock);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
